// File: rtl/mem_burst_pkg.sv
// ============================================================================
// Module : mem_burst_pkg
// Brief  : Shared widths and FSM state encoding for mem_burst_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_burst_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_CAPT  = 3'd3;
  localparam logic [2:0] S_RD_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_WR       = S_WR,
    ST_RD_ISSUE = S_RD_ISSUE,
    ST_RD_CAPT  = S_RD_CAPT,
    ST_RD_HOLD  = S_RD_HOLD,
    ST_DONE     = S_DONE
  } state_e;

endpackage : mem_burst_pkg

`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
// ============================================================================
// Module : mem_burst_ctrl
// Brief  : Burst read/write controller for a single-port synchronous memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  // write data
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  // read data
  output logic              rdo_valid,
  input  logic              rdo_ready,
  output logic [DATA_W-1:0] rdo_data,
  // memory
  output logic              mem_en,
  output logic              mem_wr_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  // status
  output logic              busy,
  output logic              done
);

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   rdo_data_q, rdo_data_d;

  logic                in_wr;
  logic                wr_hs;
  logic                rd_hs;
  logic                last_beat;

  assign in_wr     = (state_q == ST_WR);
  assign wr_hs     = in_wr && wd_valid;
  assign rd_hs     = (state_q == ST_RD_HOLD) && rdo_ready;
  assign last_beat = (beat_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    beat_cnt_d = beat_cnt_q;
    rdo_data_d = rdo_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          beat_cnt_d = cmd_len;
          state_d    = cmd_wr ? ST_WR : ST_RD_ISSUE;
        end
      end
      ST_WR: begin
        if (wr_hs) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        // memory returns data one cycle after the issue cycle
        rdo_data_d = mem_rd_data;
        state_d    = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (rd_hs) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          state_d    = last_beat ? ST_DONE : ST_RD_ISSUE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      beat_cnt_q <= '0;
      rdo_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      beat_cnt_q <= beat_cnt_d;
      rdo_data_q <= rdo_data_d;
    end
  end

  // Write strobes are combinational so the memory captures on the handshake edge.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign wd_ready    = in_wr;
  assign rdo_valid   = (state_q == ST_RD_HOLD);
  assign rdo_data    = rdo_data_q;
  assign mem_en      = wr_hs || (state_q == ST_RD_ISSUE);
  assign mem_wr_rd   = in_wr;
  assign mem_addr    = cur_addr_q;
  assign mem_wr_data = in_wr ? wd_data : '0;

endmodule : mem_burst_ctrl

`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
// ============================================================================
// Module : tb_mem_burst_ctrl
// Brief  : Directed self-checking bench for mem_burst_ctrl with a memory model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic       wd_valid = 1'b0, wd_ready;
  logic [7:0] wd_data = '0;
  logic       rdo_valid, rdo_ready = 1'b0;
  logic [7:0] rdo_data;
  logic       mem_en, mem_wr_rd;
  logic [9:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data = '0;
  logic       busy, done;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [7:0] mem [0:1023];

  mem_burst_ctrl #(.ADDR_W(10), .DATA_W(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rdo_valid(rdo_valid), .rdo_ready(rdo_ready), .rdo_data(rdo_data),
    .mem_en(mem_en), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous single-port memory, read data valid the cycle after issue
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_rd) begin
        mem[mem_addr] <= mem_wr_data;
        wr_count      <= wr_count + 1;
      end else begin
        mem_rd_data <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    tests++; if ({busy, done, wd_ready, rdo_valid, mem_en} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, wd_ready, rdo_valid, mem_en}); end
    tests++; if ({rdo_data, mem_addr, mem_wr_data} !== 26'h0) begin fails++; $display("FAIL reset_data got %h exp 0", {rdo_data, mem_addr, mem_wr_data}); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    int wc0;
    wc0 = wr_count;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 10'h010; cmd_len = 8'd3; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
    step(); cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      wd_valid = 1; wd_data = 8'(8'hA0 + i); #1;
      tests++; if ({wd_ready, mem_en, mem_wr_rd, busy, done} !== 5'b11110) begin fails++; $display("FAIL wr_ctrl beat %0d got %b exp 11110", i, {wd_ready, mem_en, mem_wr_rd, busy, done}); end
      tests++; if (mem_addr !== 10'(16 + i) || mem_wr_data !== 8'(8'hA0 + i)) begin fails++; $display("FAIL wr_addr_data beat %0d got %h/%h exp %h/%h", i, mem_addr, mem_wr_data, 10'(16 + i), 8'(8'hA0 + i)); end
      step();
    end
    wd_valid = 0; #1;
    tests++; if ({done, busy, mem_en, wd_ready} !== 4'b1100) begin fails++; $display("FAIL wr_done got %b exp 1100", {done, busy, mem_en, wd_ready}); end
    step();
    tests++; if ({done, busy, cmd_ready} !== 3'b001) begin fails++; $display("FAIL wr_idle got %b exp 001", {done, busy, cmd_ready}); end
    tests++; if (wr_count - wc0 !== 4) begin fails++; $display("FAIL wr_count got %0d exp 4", wr_count - wc0); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[16 + i] !== 8'(8'hA0 + i)) begin fails++; $display("FAIL wr_mem[%0d] got %h exp %h", 16 + i, mem[16 + i], 8'(8'hA0 + i)); end
    end
  endtask

  task automatic test_read_burst();
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 10'h010; cmd_len = 8'd3; rdo_ready = 1;
    step(); cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if ({mem_en, mem_wr_rd, rdo_valid, wd_ready} !== 4'b1000 || mem_addr !== 10'(16 + i)) begin fails++; $display("FAIL rd_issue beat %0d got %b addr %h exp 1000 addr %h", i, {mem_en, mem_wr_rd, rdo_valid, wd_ready}, mem_addr, 10'(16 + i)); end
      step();
      tests++; if ({mem_en, rdo_valid} !== 2'b00) begin fails++; $display("FAIL rd_capt beat %0d got %b exp 00", i, {mem_en, rdo_valid}); end
      step();
      tests++; if ({mem_en, rdo_valid} !== 2'b01 || rdo_data !== 8'(8'hA0 + i)) begin fails++; $display("FAIL rd_hold beat %0d got %b data %h exp 01 data %h", i, {mem_en, rdo_valid}, rdo_data, 8'(8'hA0 + i)); end
      step();
    end
    tests++; if ({done, rdo_valid, mem_en} !== 3'b100) begin fails++; $display("FAIL rd_done got %b exp 100", {done, rdo_valid, mem_en}); end
    step();
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rd_idle got %b exp 1", cmd_ready); end
  endtask

  task automatic test_wrap();
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 10'h3FF; cmd_len = 8'd1;
    step(); cmd_valid = 0;
    wd_valid = 1; wd_data = 8'h55; #1;
    tests++; if (mem_addr !== 10'h3FF) begin fails++; $display("FAIL wrap_addr0 got %h exp 3ff", mem_addr); end
    step();
    wd_data = 8'h66; #1;
    tests++; if (mem_addr !== 10'h000 || done !== 1'b0) begin fails++; $display("FAIL wrap_addr1 got %h done %b exp 000 done 0", mem_addr, done); end
    step(); wd_valid = 0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL wrap_done got %b exp 1", done); end
    step();
    tests++; if (mem[1023] !== 8'h55 || mem[0] !== 8'h66) begin fails++; $display("FAIL wrap_mem got %h/%h exp 55/66", mem[1023], mem[0]); end
  endtask

  task automatic test_backpressure();
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 10'h010; cmd_len = 8'd1; rdo_ready = 0;
    step(); cmd_valid = 0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      tests++; if ({rdo_valid, mem_en, done} !== 3'b100 || rdo_data !== 8'hA0) begin fails++; $display("FAIL bp_hold cyc %0d got %b data %h exp 100 data a0", i, {rdo_valid, mem_en, done}, rdo_data); end
      step();
    end
    rdo_ready = 1;
    step();
    tests++; if ({mem_en, rdo_valid} !== 2'b10 || mem_addr !== 10'h011) begin fails++; $display("FAIL bp_next got %b addr %h exp 10 addr 011", {mem_en, rdo_valid}, mem_addr); end
    step(); step();
    tests++; if (rdo_valid !== 1'b1 || rdo_data !== 8'hA1) begin fails++; $display("FAIL bp_beat1 got %b data %h exp 1 data a1", rdo_valid, rdo_data); end
    step();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_done got %b exp 1", done); end
    step();
  endtask

  task automatic test_write_stall();
    int wc0;
    wc0 = wr_count;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 10'h020; cmd_len = 8'd3;
    step();
    cmd_addr = 10'h300; cmd_wr = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wd_valid = 0;
        for (int s = 0; s < 4; s++) begin
          #1;
          tests++; if ({mem_en, wd_ready, cmd_ready} !== 3'b010 || mem_addr !== 10'h022) begin fails++; $display("FAIL stall cyc %0d got %b addr %h exp 010 addr 022", s, {mem_en, wd_ready, cmd_ready}, mem_addr); end
          step();
        end
      end
      wd_valid = 1; wd_data = 8'(8'hB0 + i); #1;
      tests++; if (mem_en !== 1'b1 || mem_addr !== 10'(32 + i)) begin fails++; $display("FAIL stall_beat %0d got en %b addr %h exp en 1 addr %h", i, mem_en, mem_addr, 10'(32 + i)); end
      step();
    end
    wd_valid = 0; cmd_valid = 0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done got %b exp 1", done); end
    step();
    tests++; if (wr_count - wc0 !== 4) begin fails++; $display("FAIL stall_count got %0d exp 4", wr_count - wc0); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (mem[32 + i] !== 8'(8'hB0 + i)) begin fails++; $display("FAIL stall_mem[%0d] got %h exp %h", 32 + i, mem[32 + i], 8'(8'hB0 + i)); end
    end
  endtask

  task automatic test_len255();
    int wc0;
    int bad;
    wc0 = wr_count; bad = 0;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 10'h100; cmd_len = 8'd255;
    step(); cmd_valid = 0;
    for (int i = 0; i < 256; i++) begin
      wd_valid = 1; wd_data = 8'(i); #1;
      if (done !== 1'b0 || mem_addr !== 10'(256 + i)) bad++;
      step();
    end
    wd_valid = 0;
    tests++; if (bad !== 0) begin fails++; $display("FAIL len255_beats got %0d bad beats exp 0", bad); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL len255_done got %b exp 1", done); end
    step();
    tests++; if (wr_count - wc0 !== 256) begin fails++; $display("FAIL len255_count got %0d exp 256", wr_count - wc0); end
    tests++; if (mem[256] !== 8'h00 || mem[511] !== 8'hFF) begin fails++; $display("FAIL len255_mem got %h/%h exp 00/ff", mem[256], mem[511]); end
  endtask

  task automatic test_reset_mid_read();
    int wc0;
    cmd_valid = 1; cmd_wr = 0; cmd_addr = 10'h100; cmd_len = 8'd7; rdo_ready = 1;
    step(); cmd_valid = 0;
    for (int i = 0; i < 2; i++) begin
      step(); step();
      tests++; if (rdo_data !== 8'(i)) begin fails++; $display("FAIL rst_rd_beat %0d got %h exp %h", i, rdo_data, 8'(i)); end
      step();
    end
    step(); step();
    tests++; if (rdo_valid !== 1'b1 || rdo_data !== 8'h02) begin fails++; $display("FAIL rst_rd_hold2 got %b data %h exp 1 data 02", rdo_valid, rdo_data); end
    rst = 0; #1;
    tests++; if ({cmd_ready, busy, done, rdo_valid, mem_en} !== 5'b10000 || rdo_data !== 8'h00 || mem_addr !== 10'h000) begin fails++; $display("FAIL rst_mid got %b data %h addr %h exp 10000 data 00 addr 000", {cmd_ready, busy, done, rdo_valid, mem_en}, rdo_data, mem_addr); end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL rst_no_done cyc %0d got %b exp 00", i, {done, busy}); end
    end
    rst = 1; rdo_ready = 0;
    step();
    wc0 = wr_count;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 10'h050; cmd_len = 8'd0; #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready got %b exp 1", cmd_ready); end
    step(); cmd_valid = 0;
    wd_valid = 1; wd_data = 8'h77;
    step(); wd_valid = 0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL len0_done got %b exp 1", done); end
    step();
    tests++; if (wr_count - wc0 !== 1 || mem[80] !== 8'h77) begin fails++; $display("FAIL len0_write got count %0d data %h exp 1 data 77", wr_count - wc0, mem[80]); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_backpressure();
    test_write_stall();
    test_len255();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_burst_ctrl

`default_nettype wire
